// File: rtl/mdu_alu_if.sv
// Operation/result bus of the multiply-divide ALU.
//
// Handshake: an operation is taken on a rising clock edge where in_valid
// and in_ready are both 1; alu_ctrl, data1, data2 and shamt are sampled on
// that edge only. out_valid is a one-cycle strobe with no back-pressure;
// alu_res/zero/div_zero hold their value until the next completion.
interface mdu_alu_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       alu_ctrl;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic [WIDTH-1:0] alu_res;
   logic             zero;
   logic             div_zero;
   logic             busy;
   logic [1:0]       fsm_state;

   modport master (
      output in_valid, alu_ctrl, data1, data2, shamt,
      input  in_ready, out_valid, alu_res, zero, div_zero, busy, fsm_state
   );

   modport slave (
      input  in_valid, alu_ctrl, data1, data2, shamt,
      output in_ready, out_valid, alu_res, zero, div_zero, busy, fsm_state
   );
endinterface

// File: rtl/mdu_alu.sv
// MIPS-style ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops return on the cycle after accept; MULT/DIV run one bit per
// cycle in CALC, then FIX applies signs and writes HI/LO.
module mdu_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input logic      clk,
   input logic      rst,
   mdu_alu_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   localparam logic [4:0] OP_SLL  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_AND  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b00101;
   localparam logic [4:0] OP_XOR  = 5'b00110;
   localparam logic [4:0] OP_LUI  = 5'b00111;
   localparam logic [4:0] OP_SLT  = 5'b01010;
   localparam logic [4:0] OP_SLTU = 5'b01011;
   localparam logic [4:0] OP_SRA  = 5'b01100;
   localparam logic [4:0] OP_BEQ  = 5'b01110;
   localparam logic [4:0] OP_SRL  = 5'b01111;
   localparam logic [4:0] OP_MFHI = 5'b10100;
   localparam logic [4:0] OP_MFLO = 5'b10101;
   // LUI places data2[15:0] in the top 16 bits of the word.
   localparam int LUI_SH = (WIDTH > 16) ? WIDTH - 16 : 0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   // Iteration registers: acc_hi = partial product / remainder,
   // acc_lo = multiplier / dividend-quotient, opb = multiplicand / divisor.
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             is_div_q, is_div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             out_valid_q, out_valid_d, zero_q, zero_d, div_zero_q, div_zero_d;

   logic             accept, is_multi, is_signed;
   logic [WIDTH-1:0] single_res, mag_a, mag_b, q_fix, r_fix;
   logic             single_zero;
   logic [WIDTH:0]   shifted, diff, sum;
   logic [2*WIDTH-1:0] prod;

   assign accept   = bus.in_valid && (state_q == IDLE);
   assign is_multi = (bus.alu_ctrl[4:2] == 3'b100);

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.alu_res   = res_q;
   assign bus.zero      = zero_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.fsm_state = state_q;

   // Single-cycle result and zero flag, computed from the presented operands.
   always_comb begin
      single_res = '0;
      case (bus.alu_ctrl)
         OP_ADD:  single_res = bus.data1 + bus.data2;
         OP_SUB:  single_res = bus.data1 - bus.data2;
         OP_AND:  single_res = bus.data1 & bus.data2;
         OP_OR:   single_res = bus.data1 | bus.data2;
         OP_XOR:  single_res = bus.data1 ^ bus.data2;
         OP_LUI:  single_res = bus.data2 << LUI_SH;
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
         OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
         OP_SLL:  single_res = bus.data1 << bus.shamt;
         OP_SRL:  single_res = bus.data1 >> bus.shamt;
         OP_SRA:  single_res = $signed(bus.data1) >>> bus.shamt;
         OP_MFHI: single_res = hi_q;
         OP_MFLO: single_res = lo_q;
         default: single_res = '0;
      endcase
      single_zero = (bus.alu_ctrl == OP_BEQ) ? (bus.data1 == bus.data2) : (single_res == '0);
   end

   // Next-state logic: accept, iterate one bit per cycle, sign-fix and retire.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      opb_d       = opb_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      neg_a_d     = neg_a_q;
      neg_b_d     = neg_b_q;
      dz_d        = dz_q;
      res_d       = res_q;
      zero_d      = zero_q;
      div_zero_d  = div_zero_q;
      out_valid_d = 1'b0;
      is_signed   = 1'b0;
      mag_a       = '0;
      mag_b       = '0;
      shifted     = '0;
      diff        = '0;
      sum         = '0;
      prod        = '0;
      q_fix       = '0;
      r_fix       = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_multi) begin
                  is_signed = !bus.alu_ctrl[0];
                  is_div_d  = bus.alu_ctrl[1];
                  neg_a_d   = is_signed && bus.data1[WIDTH-1];
                  neg_b_d   = is_signed && bus.data2[WIDTH-1];
                  mag_a     = neg_a_d ? -bus.data1 : bus.data1;
                  mag_b     = neg_b_d ? -bus.data2 : bus.data2;
                  acc_hi_d  = '0;
                  acc_lo_d  = bus.alu_ctrl[1] ? mag_a : mag_b;
                  opb_d     = bus.alu_ctrl[1] ? mag_b : mag_a;
                  dz_d      = bus.alu_ctrl[1] && (bus.data2 == '0);
                  cnt_d     = SHW'(WIDTH - 1);
                  state_d   = CALC;
               end else begin
                  res_d       = single_res;
                  zero_d      = single_zero;
                  div_zero_d  = 1'b0;
                  out_valid_d = 1'b1;
               end
            end
         end
         CALC: begin
            if (is_div_q) begin
               // Restoring divide: shift in the next dividend bit, subtract if it fits.
               shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
               diff    = shifted - {1'b0, opb_q};
               if (!diff[WIDTH]) begin
                  acc_hi_d = diff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = shifted[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               // Shift-add multiply: add multiplicand on a set LSB, shift right with carry.
               sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
               {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - SHW'(1);
            end
         end
         FIX: begin
            if (is_div_q) begin
               r_fix = neg_a_q ? -acc_hi_q : acc_hi_q;
               if (dz_q) begin
                  q_fix = '1;
               end else begin
                  q_fix = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
               end
            end else begin
               prod  = {acc_hi_q, acc_lo_q};
               if (neg_a_q ^ neg_b_q) begin
                  prod = -prod;
               end
               r_fix = prod[2*WIDTH-1:WIDTH];
               q_fix = prod[WIDTH-1:0];
            end
            hi_d        = r_fix;
            lo_d        = q_fix;
            res_d       = q_fix;
            zero_d      = (q_fix == '0);
            div_zero_d  = is_div_q && dz_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         opb_q       <= '0;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         dz_q        <= 1'b0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         opb_q       <= opb_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         neg_a_q     <= neg_a_d;
         neg_b_q     <= neg_b_d;
         dz_q        <= dz_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         div_zero_q  <= div_zero_d;
      end
   end
endmodule

// File: tb/tb_mdu_alu.sv
// Bench for mdu_alu (WIDTH=32): directed checks of the documented examples
// plus random single- and multi-cycle operations against a 64-bit model.
module tb_mdu_alu;
   localparam int W = 32;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic [4:0]   sops [14] = '{5'b00001, 5'b00010, 5'b00100, 5'b00101, 5'b00110,
                               5'b00111, 5'b01010, 5'b01011, 5'b00000, 5'b01111,
                               5'b01100, 5'b01110, 5'b10100, 5'b10101};

   mdu_alu_if #(.WIDTH(W), .SHW(5)) bus ();

   mdu_alu #(.WIDTH(W), .SHW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model: single-cycle ops
   function automatic logic [W-1:0] m_alu(input logic [4:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [4:0] sh);
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         5'b00001: return a + b;
         5'b00010: return a - b;
         5'b00100: return a & b;
         5'b00101: return a | b;
         5'b00110: return a ^ b;
         5'b00111: return {b[15:0], 16'h0000};
         5'b01010: return (sa < sb) ? 32'd1 : 32'd0;
         5'b01011: return (a < b) ? 32'd1 : 32'd0;
         5'b00000: return a << sh;
         5'b01111: return a >> sh;
         5'b01100: return 32'(sa >>> sh);
         5'b10100: return m_hi;
         5'b10101: return m_lo;
         default:  return 32'd0;
      endcase
   endfunction

   // reference model: multiply/divide with 64-bit arithmetic
   task automatic m_muldiv(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] e_hi, output logic [W-1:0] e_lo, output logic e_dz);
      longint sa;
      longint sb;
      logic [63:0] p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      e_dz = 1'b0;
      case (op)
         5'b10000: p = 64'(sa * sb);
         5'b10001: p = {32'd0, a} * {32'd0, b};
         5'b10010: p = (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
         default:  p = (b == 0) ? 64'd0 : {a % b, a / b};
      endcase
      if (op[1] && b == 0) begin
         p    = {a, 32'hFFFF_FFFF};
         e_dz = 1'b1;
      end
      e_hi = p[63:32];
      e_lo = p[31:0];
   endtask

   // driver: present one op #1 after an edge, accepted on the next edge
   task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = op;
      bus.data1    = a;
      bus.data2    = b;
      bus.shamt    = sh;
   endtask

   task automatic single_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [4:0] sh);
      logic [W-1:0] e_res;
      logic         e_zero;
      e_res  = m_alu(op, a, b, sh);
      e_zero = (op == 5'b01110) ? (a == b) : (e_res == 0);
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      drive(op, a, b, sh);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_res"}, bus.alu_res, e_res);
      check({tag, "_zero"}, 32'(bus.zero), 32'(e_zero));
      check({tag, "_dz"}, 32'(bus.div_zero), 32'd0);
   endtask

   task automatic multi_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      logic [W-1:0] e_hi;
      logic [W-1:0] e_lo;
      logic         e_dz;
      int           n;
      bit           bad;
      m_muldiv(op, a, b, e_hi, e_lo, e_dz);
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      drive(op, a, b, 5'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 5'b00001;
      bus.data1    = $urandom;
      bus.data2    = $urandom;
      n   = 1;
      bad = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(W + 2));
      check({tag, "_busy"}, 32'(bad), 32'd0);
      check({tag, "_res"}, bus.alu_res, e_lo);
      check({tag, "_zero"}, 32'(bus.zero), 32'(e_lo == 0));
      check({tag, "_dz"}, 32'(bus.div_zero), 32'(e_dz));
      m_hi = e_hi;
      m_lo = e_lo;
   endtask

   initial begin
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           bad;
      n_assert     = 0;
      n_fail       = 0;
      m_hi         = '0;
      m_lo         = '0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.alu_ctrl = '0;
      bus.data1    = '0;
      bus.data2    = '0;
      bus.shamt    = '0;

      // reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_res", bus.alu_res, 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_dz", 32'(bus.div_zero), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rdy", 32'(bus.in_ready), 32'd1);
      single_op("rst_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
      check("rst_mfhi_v", bus.alu_res, 32'd0);

      // directed single-cycle examples
      single_op("add", 5'b00001, 32'd7, 32'hFFFF_FFFD, 5'd0);
      check("add_v", bus.alu_res, 32'd4);
      single_op("slt", 5'b01010, 32'hFFFF_FFFF, 32'd1, 5'd0);
      check("slt_v", bus.alu_res, 32'd1);
      single_op("sltu", 5'b01011, 32'hFFFF_FFFF, 32'd1, 5'd0);
      check("sltu_v", bus.alu_res, 32'd0);
      single_op("beq_eq", 5'b01110, 32'd5, 32'd5, 5'd0);
      check("beq_eq_z", 32'(bus.zero), 32'd1);
      single_op("beq_ne", 5'b01110, 32'd5, 32'd6, 5'd0);
      check("beq_ne_z", 32'(bus.zero), 32'd0);
      single_op("sra", 5'b01100, 32'h8000_0010, 32'd0, 5'd4);
      check("sra_v", bus.alu_res, 32'hF800_0001);
      single_op("lui", 5'b00111, 32'd0, 32'h1234_ABCD, 5'd0);
      check("lui_v", bus.alu_res, 32'hABCD_0000);
      single_op("undef", 5'b11111, 32'd3, 32'd4, 5'd0);
      check("undef_z", 32'(bus.zero), 32'd1);
      @(posedge clk);
      #1;
      check("idle_ov", 32'(bus.out_valid), 32'd0);

      // directed multi-cycle examples
      multi_op("mult", 5'b10000, 32'hFFFF_FFFD, 32'd5);
      check("mult_lo", bus.alu_res, 32'hFFFF_FFF1);
      single_op("mult_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
      check("mult_hi", bus.alu_res, 32'hFFFF_FFFF);
      multi_op("div", 5'b10010, 32'hFFFF_FFF9, 32'd2);
      check("div_lo", bus.alu_res, 32'hFFFF_FFFD);
      single_op("div_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
      check("div_hi", bus.alu_res, 32'hFFFF_FFFF);
      multi_op("divu0", 5'b10011, 32'd7, 32'd0);
      check("divu0_lo", bus.alu_res, 32'hFFFF_FFFF);
      check("divu0_dz", 32'(bus.div_zero), 32'd1);
      single_op("divu0_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
      check("divu0_hi", bus.alu_res, 32'd7);
      check("dz_cleared", 32'(bus.div_zero), 32'd0);
      multi_op("divmin", 5'b10010, 32'h8000_0000, 32'hFFFF_FFFF);
      check("divmin_lo", bus.alu_res, 32'h8000_0000);
      single_op("divmin_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
      check("divmin_hi", bus.alu_res, 32'd0);

      // random single-cycle ops, back to back
      for (int i = 0; i < 60; i++) begin
         op = sops[$urandom_range(0, 13)];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
         single_op("rnd_s", op, a, b, 5'($urandom_range(0, 31)));
      end

      // random multi-cycle ops with HI/LO readback
      for (int i = 0; i < 10; i++) begin
         op = 5'b10000 + 5'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
         if (i == 0) b = 32'($urandom_range(1, 9));
         multi_op("rnd_m", op, a, b);
         single_op("rnd_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);
         single_op("rnd_mflo", 5'b10101, 32'd0, 32'd0, 5'd0);
      end

      // reset in the middle of a MULTU, with an accept attempt on the reset edge
      multi_op("pre", 5'b10001, 32'd1234, 32'd5678);
      drive(5'b10001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      drive(5'b00001, 32'd1, 32'd1, 5'd0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_rdy", 32'(bus.in_ready), 32'd1);
      check("abort_ov", 32'(bus.out_valid), 32'd0);
      bad = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) bad = 1;
      end
      check("abort_quiet", 32'(bad), 32'd0);
      m_hi = '0;
      m_lo = '0;
      single_op("abort_mflo", 5'b10101, 32'd0, 32'd0, 5'd0);
      check("abort_lo", bus.alu_res, 32'd0);
      single_op("abort_mfhi", 5'b10100, 32'd0, 32'd0, 5'd0);

      // report
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu_alu.md
MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation presented.
REQ-006 SHALL have port in_ready  output  1  block can accept; high only in IDLE.
REQ-007 SHALL have port alu_ctrl  input  5  opcode, sampled on accept.
REQ-008 SHALL have port data1  input  WIDTH  operand A (rs).
REQ-009 SHALL have port data2  input  WIDTH  operand B (rt/imm).
REQ-010 SHALL have port shamt  input  SHW  shift amount.
REQ-011 SHALL have port out_valid  output  1  one-cycle result strobe; no back-pressure.
REQ-012 SHALL have port alu_res  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered zero/equal flag.
REQ-014 SHALL have port div_zero  output  1  registered divide-by-zero flag.
REQ-015 SHALL have port busy  output  1  multi-cycle operation in flight.

Function
REQ-016 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; operands and opcode captured then; later input changes ignored.
REQ-017 Single-cycle opcodes SHALL be 00001 ADD, 00010 SUB, 00100 AND, 00101 OR, 00110 XOR, 00111 LUI ({data2[15:0],zeros}), 01010 SLT (signed, result 1/0), 01011 SLTU, 00000 SLL, 01111 SRL, 01100 SRA, 01110 BEQ, 10100 MFHI, 10101 MFLO.
REQ-018 Multi-cycle opcodes SHALL be 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH, with no overflow trap.
REQ-020 Shifts SHALL use shamt only; SRA replicates data1 MSB.
REQ-021 A single-cycle op SHALL give out_valid=1 with alu_res on the cycle after accept; in_ready stays 1, so back-to-back accepts are allowed.
REQ-022 For BEQ, zero SHALL be (data1==data2) and alu_res=0; for all other ops, zero SHALL be (alu_res==0).
REQ-023 Undefined opcodes SHALL give alu_res=0, zero=1, out_valid after one cycle.
REQ-024 FSM states SHALL be IDLE, CALC, FIX; a multi-cycle accept moves IDLE->CALC and loads operand magnitudes (signed ops) or raw values (unsigned ops).
REQ-025 CALC SHALL run exactly WIDTH iterations, counter WIDTH-1 down to 0: shift-add multiply or restoring divide, 1 bit/cycle; then CALC->FIX.
REQ-026 FIX SHALL apply sign correction, write HI/LO, pulse out_valid with alu_res=LO, then go FIX->IDLE.
REQ-027 Multi-cycle latency SHALL be out_valid exactly WIDTH+2 cycles after the accept edge; busy=1 and in_ready=0 over that whole interval.
REQ-028 Multiply SHALL write the full 2*WIDTH product, HI=upper half, LO=lower half.
REQ-029 Divide SHALL give LO=quotient truncated toward zero and HI=remainder, with remainder sign equal to dividend sign.
REQ-030 Divide by zero SHALL give LO=all ones, HI=dividend, div_zero=1 with the same latency; any other completed op clears div_zero.
REQ-031 Signed DIV of MIN by -1 SHALL give LO=MIN, HI=0, div_zero=0.
REQ-032 MFHI/MFLO SHALL return HI/LO as last written; they cannot issue while busy.
REQ-033 HI/LO SHALL change only in FIX.

Reset
REQ-034 While rst=1 at an edge, the block SHALL enter IDLE and clear alu_res, HI, LO, counter, out_valid, zero, div_zero and busy to 0; in_ready=1 on the following cycle.
REQ-035 Reset mid-operation SHALL abort it: no out_valid, HI/LO=0; an accept attempted in the reset cycle is ignored.

Verification
REQ-036 ADD 7, 0xFFFFFFFD (WIDTH=32) -> next cycle out_valid=1, alu_res=4, zero=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-037 BEQ 5,5 then BEQ 5,6 back-to-back -> zero=1 then zero=0, on consecutive cycles.
REQ-038 MULT 0xFFFFFFFD, 5 -> in_ready=0 for 34 cycles, out_valid at cycle 34, LO=0xFFFFFFF1; then MFHI -> 0xFFFFFFFF.
REQ-039 DIV 0xFFFFFFF9, 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7,0 -> LO=0xFFFFFFFF, HI=7, div_zero=1; a following ADD clears div_zero.
REQ-040 rst at cycle 10 of MULTU -> next cycle busy=0, in_ready=1, no out_valid; MFLO -> 0.
